// File: rtl/spi_pkg.sv
// spi_pkg: shared command encodings, widths and FSM states for the SPI master.
package spi_pkg;
    localparam int FRAME_W = 10;
    localparam int DATA_W = 8;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV,
        ST_END
    } state_t;
endpackage

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: frame load/shift-out register, MISO shift-in and down-counter.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               shift,
    input  logic               capture,
    input  logic               miso,
    input  logic               cnt_load,
    input  logic [3:0]         cnt_val,
    output logic [1:0]         tx_hi,
    output logic [3:0]         cnt,
    output logic [DATA_W-1:0]  rx_next
);
    logic [FRAME_W-1:0] tx;
    logic [DATA_W-2:0]  rx;
    assign tx_hi = tx[FRAME_W-1:FRAME_W-2];
    assign rx_next = {rx, miso};
    // Counter free-runs down to zero; the FSM reloads it on entering each timed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx <= '0;
            rx <= '0;
            cnt <= '0;
        end else begin
            tx <= load ? frame : shift ? {tx[FRAME_W-2:0], 1'b0} : tx;
            rx <= capture ? rx_next[DATA_W-2:0] : rx;
            cnt <= cnt_load ? cnt_val : cnt - 4'(cnt != 4'd0);
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: serialises 10-bit RAM command frames onto MOSI and captures read-data bytes from MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_GAP = 2,
    parameter int END_GAP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SS_n
);
    state_t state, state_n;
    logic rd, ss_n_d, mosi_d, rsp_valid_d;
    logic load, shift, capture, cnt_load;
    logic [3:0] cnt_val, cnt;
    logic [1:0] tx_hi;
    logic [DATA_W-1:0] rx_next;
    assign cmd_ready = state == ST_IDLE;
    assign busy = state != ST_IDLE;
    spi_master_shifter u_shifter (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .frame({cmd_type, cmd_data}),
        .shift(shift),
        .capture(capture),
        .miso(MISO),
        .cnt_load(cnt_load),
        .cnt_val(cnt_val),
        .tx_hi(tx_hi),
        .cnt(cnt),
        .rx_next(rx_next)
    );
    always_comb begin
        state_n = state;
        ss_n_d = SS_n;
        mosi_d = MOSI;
        rsp_valid_d = 1'b0;
        load = 1'b0;
        shift = 1'b0;
        capture = 1'b0;
        cnt_load = 1'b0;
        cnt_val = '0;
        case (state)
            ST_IDLE: if (cmd_valid) begin
                load = 1'b1;
                ss_n_d = 1'b0;
                mosi_d = cmd_type[1];
                state_n = ST_START;
            end
            ST_START: begin
                mosi_d = tx_hi[1];
                cnt_load = 1'b1;
                cnt_val = 4'd9;
                state_n = ST_SHIFT;
            end
            ST_SHIFT: if (cnt != 4'd0) begin
                mosi_d = tx_hi[0];
                shift = 1'b1;
            end else begin
                mosi_d = 1'b0;
                ss_n_d = !rd;
                cnt_load = 1'b1;
                cnt_val = rd ? 4'(RD_GAP - 1) : 4'(END_GAP - 1);
                state_n = rd ? ST_WAIT : ST_END;
            end
            ST_WAIT: if (cnt == 4'd0) begin
                cnt_load = 1'b1;
                cnt_val = 4'd7;
                state_n = ST_RECV;
            end
            ST_RECV: begin
                capture = 1'b1;
                if (cnt == 4'd0) begin
                    ss_n_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val = 4'(END_GAP - 1);
                    state_n = ST_END;
                end
            end
            ST_END: if (cnt == 4'd0) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            SS_n <= 1'b1;
            MOSI <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rd <= 1'b0;
        end else begin
            state <= state_n;
            SS_n <= ss_n_d;
            MOSI <= mosi_d;
            rsp_valid <= rsp_valid_d;
            rsp_data <= rsp_valid_d ? rx_next : rsp_data;
            rd <= load ? cmd_type == CMD_RD_DATA : rd;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed frame-level checks of MOSI framing, SS_n timing, read capture and reset.
module tb_spi_master;
    import spi_pkg::*;
    localparam int RD_GAP = 2;
    localparam int END_GAP = 1;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid, cmd_ready, rsp_valid, busy, MOSI, MISO, SS_n;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data, rsp_data;
    int n_chk = 0, n_fail = 0;
    spi_master #(.RD_GAP(RD_GAP), .END_GAP(END_GAP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type(cmd_type),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .MOSI(MOSI),
        .MISO(MISO),
        .SS_n(SS_n)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Issues one command, plays the slave's MISO byte in the receive window and checks the frame.
    task automatic run_cmd(input logic [1:0] t, input logic [7:0] d, input logic [7:0] mb);
        logic [9:0] f;
        logic [10:0] seq;
        int k, bad;
        logic is_rd;
        f = {t, d};
        is_rd = t == CMD_RD_DATA;
        seq = '0;
        k = 0;
        bad = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type = t;
        cmd_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_type = ~t;
        cmd_data = ~d;
        check("busy_on", busy, 1);
        while (!SS_n && k < 40) begin
            if (k < 11) seq = {seq[9:0], MOSI};
            else if (MOSI) bad++;
            MISO = (k >= 11 + RD_GAP && k < 19 + RD_GAP) ? mb[7 - (k - 11 - RD_GAP)] : 1'b0;
            k++;
            @(posedge clk);
            #1;
        end
        check("ss_low_len", k, is_rd ? 11 + RD_GAP + 8 : 11);
        check("mosi_seq", seq, {f[9], f});
        check("rsp_valid_edge", rsp_valid, is_rd);
        if (is_rd) begin
            check("mosi_quiet", bad, 0);
            check("rsp_data", rsp_data, mb);
        end
        @(posedge clk);
        #1;
        check("rsp_valid_clr", rsp_valid, 0);
        check("idle_ready", cmd_ready, 1);
    endtask
    initial begin
        int k, g;
        logic rdy;
        cmd_valid = 1'b0;
        cmd_type = '0;
        cmd_data = '0;
        MISO = 1'b0;
        repeat (4) begin
            @(negedge clk);
            MISO = ~MISO;
        end
        check("rst_ss_n", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ss_n", SS_n, 1);
        check("post_rst_mosi", MOSI, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_rsp_data", rsp_data, 0);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        run_cmd(CMD_WR_ADDR, 8'h3C, 8'h00);
        run_cmd(CMD_WR_DATA, 8'hA5, 8'h00);
        run_cmd(CMD_RD_ADDR, 8'h3C, 8'h00);
        run_cmd(CMD_RD_DATA, 8'h00, 8'hA5);
        run_cmd(CMD_WR_ADDR, 8'hFF, 8'h00);
        check("rsp_data_held", rsp_data, 8'hA5);
        run_cmd(CMD_RD_DATA, 8'hC3, 8'h81);
        // Back-to-back with cmd_valid held high across the first frame.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type = CMD_WR_DATA;
        cmd_data = 8'h11;
        @(posedge clk);
        #1;
        k = 0;
        while (!SS_n && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        g = 0;
        rdy = 1'b0;
        while (SS_n && g < 40) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            g++;
        end
        cmd_valid = 1'b0;
        check("b2b_first_len", k, 11);
        check("b2b_gap", g, END_GAP + 1);
        check("b2b_ready_before_accept", rdy, 1);
        check("b2b_second_busy", busy, 1);
        k = 0;
        while (!SS_n && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("b2b_second_len", k, 11);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_drain_busy", busy, 0);
        // Reset during the 5th SHIFT bit of a write.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type = CMD_WR_DATA;
        cmd_data = 8'hFF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_abort_ss_n", SS_n, 0);
        rst_n = 1'b0;
        #1;
        check("abort_ss_n", SS_n, 1);
        check("abort_mosi", MOSI, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(CMD_WR_ADDR, 8'h42, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
